jkff_bank_sequencer: RTL

Command-driven controller that sequences an external bank of WIDTH JK flip-flops sharing the same clock. It accepts one command at a time over a valid/ready handshake, drives per-bit J/K vectors, and reads back the bank's Q vector to compute multi-step sequences such as binary up/down counting. It converts register-level operations (clear, set, load, toggle, count) into JK excitation, so no other block drives raw J/K.

---
 rtl/jkff_bank_sequencer_if.sv | 31 +++
 rtl/jkff_bank_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/jkff_bank_sequencer_if.sv
// Command bus between a host and the JK bank sequencer: the valid/ready
// command handshake, the abort request and the completion/status flags.
interface jkff_bank_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic             aborted;

  // Host side: issues commands and observes status.
  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, abort,
    input  cmd_ready, busy, done, err, aborted
  );

  // Sequencer side: accepts commands and reports status.
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, abort,
    output cmd_ready, busy, done, err, aborted
  );

endinterface

// File: rtl/jkff_bank_sequencer.sv
// JK bank sequencer: turns register-level commands (clear, set, load,
// toggle, count) into per-bit J/K excitation for an external bank of JK
// flip-flops that shares Clock, and reads the bank back through q_in to
// chain multi-step count sequences. J/K are only nonzero in APPLY.
module jkff_bank_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    Clock,
  input  logic                    reset,
  jkff_bank_sequencer_if.slave    cmd,
  input  logic [WIDTH-1:0]        q_in,
  output logic [WIDTH-1:0]        j_out,
  output logic [WIDTH-1:0]        k_out
);

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_CLEAR   = 3'b001;
  localparam logic [2:0] OP_SETALL  = 3'b010;
  localparam logic [2:0] OP_LOAD    = 3'b011;
  localparam logic [2:0] OP_TOGGLE  = 3'b100;
  localparam logic [2:0] OP_CNT_UP  = 3'b101;
  localparam logic [2:0] OP_CNT_DN  = 3'b110;
  localparam logic [2:0] OP_RSVD    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // True for the two opcodes that run a multi-step count sequence.
  function automatic logic is_count(input logic [2:0] op);
    return (op == OP_CNT_UP) || (op == OP_CNT_DN);
  endfunction

  // J/K excitation for one step of an opcode. Counting uses the classic
  // ripple-toggle terms: bit i toggles when all lower bits are 1 (up) or
  // all lower bits are 0 (down). Returns {j, k}.
  function automatic logic [2*WIDTH-1:0] jk_pattern(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] data,
    input logic [WIDTH-1:0] q
  );
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q[i-1];
      t_dn[i] = t_dn[i-1] & ~q[i-1];
    end
    case (op)
      OP_CLEAR: begin
        j = {WIDTH{1'b0}};
        k = {WIDTH{1'b1}};
      end
      OP_SETALL: begin
        j = {WIDTH{1'b1}};
        k = {WIDTH{1'b0}};
      end
      OP_LOAD: begin
        j = data;
        k = ~data;
      end
      OP_TOGGLE: begin
        j = data;
        k = data;
      end
      OP_CNT_UP: begin
        j = t_up;
        k = t_up;
      end
      OP_CNT_DN: begin
        j = t_dn;
        k = t_dn;
      end
      default: begin
        j = {WIDTH{1'b0}};
        k = {WIDTH{1'b0}};
      end
    endcase
    return {j, k};
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [2:0]       op_r;
  logic [2:0]       op_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [WIDTH-1:0] j_r;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_r;
  logic [WIDTH-1:0] k_s;
  logic             err_r;
  logic             err_s;
  logic             aborted_r;
  logic             aborted_s;
  logic             done_r;
  logic             busy_r;
  logic             ready_r;

  // Next-state, next J/K pattern, step counter and status flags.
  always_comb begin
    state_s   = state_r;
    op_s      = op_r;
    cnt_s     = cnt_r;
    j_s       = {WIDTH{1'b0}};
    k_s       = {WIDTH{1'b0}};
    err_s     = err_r;
    aborted_s = aborted_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd.cmd_valid && ready_r) begin
          op_s      = cmd.cmd_op;
          err_s     = 1'b0;
          aborted_s = 1'b0;
          if (is_count(cmd.cmd_op)) begin
            cnt_s = cmd.cmd_count;
          end else begin
            cnt_s = {CNT_W{1'b0}};
          end
          if ((cmd.cmd_op == OP_NOP) || (cmd.cmd_op == OP_RSVD) ||
              (is_count(cmd.cmd_op) && (cmd.cmd_count == {CNT_W{1'b0}}))) begin
            // Nothing to drive: complete immediately.
            state_s = ST_DONE;
            err_s   = (cmd.cmd_op == OP_RSVD);
          end else begin
            {j_s, k_s} = jk_pattern(cmd.cmd_op, cmd.cmd_data, q_in);
            state_s    = ST_APPLY;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_APPLY: begin
        // The bank samples the current pattern on this edge regardless of abort.
        if (is_count(op_r)) begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_s = cnt_r;
        end
        if (cmd.abort) begin
          state_s   = ST_DONE;
          aborted_s = 1'b1;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cmd.abort) begin
          state_s   = ST_DONE;
          aborted_s = 1'b1;
        end else if (is_count(op_r) && (cnt_r != {CNT_W{1'b0}})) begin
          // q_in now holds the post-step value; derive the next step from it.
          {j_s, k_s} = jk_pattern(op_r, {WIDTH{1'b0}}, q_in);
          state_s    = ST_APPLY;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      op_r      <= 3'b000;
      cnt_r     <= {CNT_W{1'b0}};
      j_r       <= {WIDTH{1'b0}};
      k_r       <= {WIDTH{1'b0}};
      err_r     <= 1'b0;
      aborted_r <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_s;
      op_r      <= op_s;
      cnt_r     <= cnt_s;
      j_r       <= j_s;
      k_r       <= k_s;
      err_r     <= err_s;
      aborted_r <= aborted_s;
      done_r    <= (state_s == ST_DONE);
      busy_r    <= (state_s != ST_IDLE);
      ready_r   <= (state_s == ST_IDLE);
    end
  end

  assign j_out         = j_r;
  assign k_out         = k_r;
  assign cmd.cmd_ready = ready_r;
  assign cmd.busy      = busy_r;
  assign cmd.done      = done_r;
  assign cmd.err       = err_r;
  assign cmd.aborted   = aborted_r;

endmodule
